hdmi_pll_lock_monitor: RTL
==========================

# hdmi_pll_lock_monitor

Supervises the HDMI PLL after the PLL charge-pump/loop-filter calibration stage. It consumes that stage's qualified lock output and drives that stage's reset input to request recalibration. It holds the TMDS/serializer domain in reset until lock has been continuously stable for a programmable time. It also detects loss of lock during operation and gives up after a bounded number of failed acquisitions.

## Interface
Parameters:
- CLK_PERIOD, 50: CLKIN period in ns.
- STABLE_TIME, 1_000_000: ns of continuous lock required before release. STABLE_CYC = ceil(STABLE_TIME/CLK_PERIOD), minimum 1.
- ACQ_TIME, 50_000_000: ns allowed per acquisition attempt. ACQ_CYC = ceil(ACQ_TIME/CLK_PERIOD). ACQ_CYC > STABLE_CYC.
- LOSS_CYC, 16: consecutive unlocked cycles in RUN that declare loss. Minimum 1.
- RECAL_CYC, 8: width of the recalibration request pulse, in cycles. Minimum 1.
- MAX_RETRY, 3: failed acquisitions tolerated before FAIL. Range 0..15.

Ports:
- CLKIN  in  1  system clock.
- I_RST  in  1  reset, synchronous, active-high.
- LOCK_IN  in  1  qualified lock from calibration stage. Asynchronous to CLKIN.
- O_RECAL  out  1  high = hold calibration stage in reset (connects to its I_RST).
- O_SYS_RST  out  1  high = downstream HDMI logic held in reset.
- O_READY  out  1  high = PLL lock stable, downstream released.
- O_FAIL  out  1  high = acquisition abandoned.
- O_RETRY_CNT  out  4  failed acquisitions since last RUN.

## Operation
- LOCK_IN passes through a 2-flop synchronizer, giving lock_s. All logic uses lock_s only.
- States: RECAL, ACQUIRE, RUN, FAIL. One counter, cnt, is cleared on every state change.
- Outputs decode from the state register only:
  - O_RECAL = (RECAL).
  - O_SYS_RST = not RUN.
  - O_READY = (RUN).
  - O_FAIL = (FAIL).
- Reset (I_RST high at an edge): state=RECAL, cnt=0, retry=0, synchronizer flops=0. Resulting outputs: O_RECAL=1, O_SYS_RST=1, O_READY=0, O_FAIL=0, O_RETRY_CNT=0.
- RECAL: cnt increments each cycle. When cnt==RECAL_CYC-1, go to ACQUIRE. O_RECAL is therefore high exactly RECAL_CYC cycles per entry.
- ACQUIRE: two counters run.
  - acq counter increments every cycle.
  - stable counter increments while lock_s=1 and clears to 0 on lock_s=0.
  - stable counter reaching STABLE_CYC (lock_s high STABLE_CYC consecutive cycles) → RUN, and retry clears to 0.
  - Otherwise, acq counter reaching ACQ_CYC-1 → timeout:
    - if retry==MAX_RETRY → FAIL, retry unchanged;
    - else retry+1 → RECAL.
  - Stable completion and timeout on the same cycle: RUN wins.
- RUN: loss counter counts consecutive lock_s=0 cycles and clears on lock_s=1.
  - Reaching LOSS_CYC → RECAL; retry stays 0.
  - Dropouts shorter than LOSS_CYC have no effect.
- FAIL: terminal. Only I_RST leaves it.
- I_RST has priority over every transition in every state, including mid-RECAL and mid-RUN.
- Counter widths are sized by $clog2 of the largest terminal value + 1. No counter wraps; each saturates or clears at its terminal value.

## Timing
- LOCK_IN to lock_s latency: 2 cycles.
- After I_RST deasserts, O_RECAL stays high for RECAL_CYC cycles, then falls.
- If LOCK_IN rises at edge k and stays high, O_READY rises and O_SYS_RST falls at edge k+2+STABLE_CYC.
- If LOCK_IN falls at edge k while in RUN, O_READY falls and O_RECAL rises at edge k+2+LOSS_CYC.
- Acquisition timeout occurs ACQ_CYC cycles after ACQUIRE entry. With LOCK_IN stuck low, FAIL is reached after MAX_RETRY+1 attempts, where each attempt costs RECAL_CYC+ACQ_CYC cycles.
- O_RETRY_CNT updates on the same edge as the RECAL or FAIL transition.
- All outputs are glitch-free (decoded from registered state).

## Test plan
Bench parameters: CLK_PERIOD=10, STABLE_TIME=100 (10 cyc), ACQ_TIME=1000 (100 cyc), LOSS_CYC=4, RECAL_CYC=8, MAX_RETRY=2.
- Clean bring-up: release I_RST; drive LOCK_IN high at cycle 20 after release → O_RECAL high for cycles 0–7; O_READY=1 and O_SYS_RST=0 from cycle 32; O_RETRY_CNT=0.
- Chatter in ACQUIRE: LOCK_IN high 9 cycles, low 1, high continuously → no RUN after the first 9 cycles; O_READY rises 12 cycles after the final rise.
- Loss filter: in RUN, LOCK_IN low for 3 cycles → O_READY stays 1. Then low for 4 cycles → O_READY falls 6 cycles after the fall, O_RECAL high 8 cycles, then re-acquisition.
- No lock: LOCK_IN held 0 → three O_RECAL pulses; O_RETRY_CNT steps 1, 2; O_FAIL=1 at cycle 324 after release and stays high; toggling LOCK_IN has no effect until I_RST.
- Boundary: lock_s stable count completes on the acquisition timeout cycle → RUN entered, O_RETRY_CNT cleared, O_FAIL=0.
- Reset mid-operation: assert I_RST for 1 cycle in RUN and again in FAIL → on the next edge, O_RECAL=1, O_SYS_RST=1, O_READY=0, O_FAIL=0, O_RETRY_CNT=0.

Source files
------------

// File: rtl/hdmi_pll_lock_monitor.sv
// Supervises the HDMI PLL calibration stage. It requests recalibration, waits for a
// stable lock, releases the TMDS domain, and gives up after too many failed attempts.
module hdmi_pll_lock_monitor #(
  parameter int CLK_PERIOD  = 50,
  parameter int STABLE_TIME = 1_000_000,
  parameter int ACQ_TIME    = 50_000_000,
  parameter int LOSS_CYC    = 16,
  parameter int RECAL_CYC   = 8,
  parameter int MAX_RETRY   = 3
) (
  input  logic       CLKIN,
  input  logic       I_RST,
  input  logic       LOCK_IN,
  output logic       O_RECAL,
  output logic       O_SYS_RST,
  output logic       O_READY,
  output logic       O_FAIL,
  output logic [3:0] O_RETRY_CNT
);

  localparam int STABLE_RAW = (STABLE_TIME + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int STABLE_CYC = (STABLE_RAW < 1) ? 1 : STABLE_RAW;
  localparam int ACQ_CYC    = (ACQ_TIME + CLK_PERIOD - 1) / CLK_PERIOD;

  localparam int CNT_MAX_A  = (RECAL_CYC > LOSS_CYC) ? RECAL_CYC : LOSS_CYC;
  localparam int CNT_MAX    = (ACQ_CYC > CNT_MAX_A) ? ACQ_CYC : CNT_MAX_A;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int STB_W      = $clog2(STABLE_CYC + 1);

  localparam logic [CNT_W-1:0] RECAL_LAST  = CNT_W'(RECAL_CYC - 1);
  localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'(ACQ_CYC - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_CYC - 1);
  localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  // One-hot so every output is a single flop bit and cannot glitch.
  localparam logic [3:0] ST_RECAL   = 4'b0001;
  localparam logic [3:0] ST_ACQUIRE = 4'b0010;
  localparam logic [3:0] ST_RUN     = 4'b0100;
  localparam logic [3:0] ST_FAIL    = 4'b1000;

  logic             r_sync1;
  logic             r_lock_s;
  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [STB_W-1:0] r_stable;
  logic [3:0]       r_retry;

  logic [3:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [STB_W-1:0] w_stable_nxt;
  logic [3:0]       w_retry_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_retry_nxt  = r_retry;
    w_stable_nxt = '0;
    w_cnt_nxt    = r_cnt + CNT_W'(1);

    case (r_state)
      ST_RECAL: begin
        if (r_cnt == RECAL_LAST) w_state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (r_lock_s) w_stable_nxt = r_stable + STB_W'(1);
        // A stable lock completing on the timeout cycle still counts as success.
        if (r_lock_s && (r_stable == STABLE_LAST)) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = '0;
        end else if (r_cnt == ACQ_LAST) begin
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt = ST_RECAL;
            w_retry_nxt = r_retry + 4'd1;
          end
        end
      end
      ST_RUN: begin
        if (r_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LOSS_LAST) begin
          w_state_nxt = ST_RECAL;
        end
      end
      ST_FAIL: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_RECAL;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt    = '0;
      w_stable_nxt = '0;
    end
  end

  always_ff @(posedge CLKIN) begin
    if (I_RST) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
      r_state  <= ST_RECAL;
      r_cnt    <= '0;
      r_stable <= '0;
      r_retry  <= '0;
    end else begin
      r_sync1  <= LOCK_IN;
      r_lock_s <= r_sync1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_retry  <= w_retry_nxt;
    end
  end

  assign O_RECAL     = r_state[0];
  assign O_READY     = r_state[2];
  assign O_SYS_RST   = ~r_state[2];
  assign O_FAIL      = r_state[3];
  assign O_RETRY_CNT = r_retry;

endmodule
